// File: rtl/lupdate_if.sv
// lupdate_if: one direction of the 134-bit packet stream between pipeline stages.
//   data_wr       word strobe
//   data          [133:132] 01 head, 11 middle, 10 tail; [131:128] reserved; [127:0] payload
//   data_valid    packet-valid flag, meaningful on the tail only
//   data_valid_wr strobe for data_valid
// master drives the stream, slave consumes it.
interface lupdate_if;
    logic         data_wr;
    logic [133:0] data;
    logic         data_valid;
    logic         data_valid_wr;

    modport master (output data_wr, data, data_valid, data_valid_wr);
    modport slave  (input  data_wr, data, data_valid, data_valid_wr);
endinterface

// File: rtl/lupdate.sv
// lupdate: recognises beacon update messages from the CNC addressed to this
// node, loads the beacon configuration registers from them and removes them
// from the stream. All other words pass through a 3-stage delay line.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_lu   (slave)       input stream from lreport
//   out_lu  (master)      delayed output stream (3 cycles)
//   in_local_mac_id       this node's MAC
//   direction, token_bucket_para, direct_mac_addr   beacon config registers
//   update_cnt            number of committed updates (wraps)
// Build option: LUPDATE_FWD_UPDATE_EN forwards update packets unmodified.
module lupdate #(
    parameter logic [47:0] CNC_MAC  = 48'h010203040506,
    parameter logic [3:0]  UPD_TYPE = 4'hf
) (
    input  logic        clk,
    input  logic        rst_n,
    lupdate_if.slave    in_lu,
    lupdate_if.master   out_lu,
    input  logic [47:0] in_local_mac_id,
    output logic        direction,
    output logic [31:0] token_bucket_para,
    output logic [47:0] direct_mac_addr,
    output logic [31:0] update_cnt
);

`ifdef LUPDATE_FWD_UPDATE_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_UPD} state_t;

    typedef struct packed {
        logic [133:0] data;
        logic         wr;
        logic         valid;
        logic         vwr;
        logic         drop;
    } stage_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         id_q, id_d;
    logic         cap_q, cap_d;
    logic [47:0]  sh_mac_q, sh_mac_d;
    logic         sh_dir_q, sh_dir_d;
    logic [31:0]  sh_tok_q, sh_tok_d;
    logic [47:0]  mac_q, mac_d;
    logic         dir_q, dir_d;
    logic [31:0]  tok_q, tok_d;
    logic [31:0]  ucnt_q, ucnt_d;
    stage_t [2:0] stg_q, stg_d;
    // Packet membership and packet id of the words in stages 1 and 2, used to
    // retro-tag the words that preceded the match word.
    logic [1:0]   mem_q, mem_d;
    logic [1:0]   pid_q, pid_d;

    logic         head, tail, open, in_pkt, cur_id, match, is_upd, at6, commit, drop_eff;
    logic [3:0]   idx_now;
    logic [127:0] pl;

    always_comb begin
        pl       = in_lu.data[127:0];
        head     = in_lu.data_wr && (in_lu.data[133:132] == 2'b01);
        tail     = in_lu.data_wr && (in_lu.data[133:132] == 2'b10);
        open     = (state_q != ST_IDLE);
        idx_now  = head ? 4'd0 : ((cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1);
        in_pkt   = head || (open && in_lu.data_wr);
        // Each head starts a new packet id so tags never leak into a neighbour.
        cur_id   = head ? ~id_q : id_q;
        match    = (state_q == ST_PKT) && in_lu.data_wr && !head && (idx_now == 4'd2) &&
                   (pl[127:80] == in_local_mac_id) && (pl[79:32] == CNC_MAC) &&
                   (pl[31:16] == 16'h88f7) && (pl[11:8] == UPD_TYPE);
        is_upd   = match || ((state_q == ST_UPD) && in_lu.data_wr && !head);
        at6      = (state_q == ST_UPD) && in_lu.data_wr && !head && (idx_now == 4'd6);
        // A 7-word update has word 6 as its tail, so the capture may be this word.
        commit   = (state_q == ST_UPD) && tail && in_lu.data_valid && (cap_q || at6);

        cnt_d = cnt_q;
        if (head)
            cnt_d = 4'd0;
        else if (in_lu.data_wr)
            cnt_d = idx_now;
        id_d = cur_id;

        state_d = state_q;
        if (head)
            state_d = ST_PKT;
        else if (open && in_lu.data_wr) begin
            if (tail)
                state_d = ST_IDLE;
            else if (match)
                state_d = ST_UPD;
        end

        sh_mac_d = sh_mac_q;
        sh_dir_d = sh_dir_q;
        sh_tok_d = sh_tok_q;
        cap_d    = cap_q;
        if (at6) begin
            sh_mac_d = pl[127:80];
            sh_dir_d = pl[79];
            sh_tok_d = pl[63:32];
            cap_d    = 1'b1;
        end
        if (head || tail)
            cap_d = 1'b0;

        mac_d  = mac_q;
        dir_d  = dir_q;
        tok_d  = tok_q;
        ucnt_d = ucnt_q;
        if (commit) begin
            mac_d  = at6 ? pl[127:80] : sh_mac_q;
            dir_d  = at6 ? pl[79]     : sh_dir_q;
            tok_d  = at6 ? pl[63:32]  : sh_tok_q;
            ucnt_d = ucnt_q + 32'd1;
        end

        stg_d[0].data  = in_lu.data;
        stg_d[0].wr    = in_lu.data_wr;
        stg_d[0].valid = in_lu.data_valid;
        stg_d[0].vwr   = in_lu.data_valid_wr;
        stg_d[0].drop  = is_upd;
        mem_d[0]       = in_pkt;
        pid_d[0]       = cur_id;

        stg_d[1]       = stg_q[0];
        stg_d[1].drop  = stg_q[0].drop | (match & mem_q[0] & (pid_q[0] == cur_id));
        mem_d[1]       = mem_q[0];
        pid_d[1]       = pid_q[0];

        stg_d[2]       = stg_q[1];
        stg_d[2].drop  = stg_q[1].drop | (match & mem_q[1] & (pid_q[1] == cur_id));

        drop_eff             = stg_q[2].drop & ~FWD_EN;
        out_lu.data_wr       = stg_q[2].wr    & ~drop_eff;
        out_lu.data          = drop_eff ? '0 : stg_q[2].data;
        out_lu.data_valid    = stg_q[2].valid & ~drop_eff;
        out_lu.data_valid_wr = stg_q[2].vwr   & ~drop_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            cap_q    <= 1'b0;
            sh_mac_q <= '0;
            sh_dir_q <= 1'b0;
            sh_tok_q <= '0;
            mac_q    <= '0;
            dir_q    <= 1'b0;
            tok_q    <= '0;
            ucnt_q   <= '0;
            stg_q    <= '0;
            mem_q    <= '0;
            pid_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            cap_q    <= cap_d;
            sh_mac_q <= sh_mac_d;
            sh_dir_q <= sh_dir_d;
            sh_tok_q <= sh_tok_d;
            mac_q    <= mac_d;
            dir_q    <= dir_d;
            tok_q    <= tok_d;
            ucnt_q   <= ucnt_d;
            stg_q    <= stg_d;
            mem_q    <= mem_d;
            pid_q    <= pid_d;
        end
    end

    assign direction         = dir_q;
    assign token_bucket_para = tok_q;
    assign direct_mac_addr   = mac_q;
    assign update_cnt        = ucnt_q;

endmodule

// File: tb/tb_lupdate.sv
// tb_lupdate: scoreboard bench for lupdate. Forwarded words are queued with
// their due cycle when driven and matched against the output stream.
module tb_lupdate;
    localparam logic [47:0] CNC   = 48'h010203040506;
    localparam logic [47:0] LOCAL = 48'h0a0b0c0d0e0f;
`ifdef LUPDATE_FWD_UPDATE_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        direction;
    logic [31:0] token_bucket_para;
    logic [47:0] direct_mac_addr;
    logic [31:0] update_cnt;

    lupdate_if in_if ();
    lupdate_if out_if ();

    lupdate #(.CNC_MAC(CNC), .UPD_TYPE(4'hf)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_lu             (in_if),
        .out_lu            (out_if),
        .in_local_mac_id   (LOCAL),
        .direction         (direction),
        .token_bucket_para (token_bucket_para),
        .direct_mac_addr   (direct_mac_addr),
        .update_cnt        (update_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [135:0] v;
        int           t;
    } exp_t;
    exp_t sb[$];

    logic [133:0] pkt[$];
    logic [47:0]  m_mac = '0;
    logic         m_dir = 1'b0;
    logic [31:0]  m_tok = '0;
    logic [31:0]  m_cnt = '0;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_if.data_wr) begin
            if (sb.size() == 0)
                check("unexp_wr", 136'(out_if.data_wr), 136'(0));
            else begin
                exp_t e;
                e = sb.pop_front();
                check("data", {out_if.data_valid_wr, out_if.data_valid, out_if.data}, e.v);
                check("lat", 136'(cyc), 136'(e.t));
            end
        end else if (out_if.data !== '0 || out_if.data_valid_wr !== 1'b0)
            check("idle_zero", {out_if.data_valid_wr, out_if.data_valid, out_if.data}, '0);
    end

    task automatic build(input int n, input logic [47:0] dst, input logic [15:0] eth,
                         input logic [127:0] w6, input bit no_tail);
        logic [127:0] p;
        logic [1:0]   h;
        pkt.delete();
        for (int i = 0; i < n; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            if (i == 2) p = {dst, CNC, eth, 4'h0, 4'hf, 8'h00};
            if (i == 6) p = w6;
            h = (i == 0) ? 2'b01 : ((i == n - 1 && !no_tail) ? 2'b10 : 2'b11);
            pkt.push_back({h, 4'h0, p});
        end
    endtask

    task automatic send(input bit valid);
        bit           upd, has_tail, last;
        logic [127:0] w2;
        int           n;
        n        = pkt.size();
        w2       = (n >= 3) ? pkt[2][127:0] : '0;
        upd      = (n >= 3) && (w2[127:80] == LOCAL) && (w2[79:32] == CNC) &&
                   (w2[31:16] == 16'h88f7) && (w2[11:8] == 4'hf);
        has_tail = (pkt[n-1][133:132] == 2'b10);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            last = (i == n - 1) && has_tail;
            in_if.data_wr       = 1'b1;
            in_if.data          = pkt[i];
            in_if.data_valid_wr = last;
            in_if.data_valid    = last & valid;
            if (!upd || FWD)
                sb.push_back('{{last, last & valid, pkt[i]}, cyc + 3});
        end
        if (upd && has_tail && valid && n >= 7) begin
            m_mac = pkt[6][127:80];
            m_dir = pkt[6][79];
            m_tok = pkt[6][63:32];
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_if.data_wr       = 1'b0;
            in_if.data          = '0;
            in_if.data_valid    = 1'b0;
            in_if.data_valid_wr = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_mac"}, 136'(direct_mac_addr), 136'(m_mac));
        check({tag, "_dir"}, 136'(direction), 136'(m_dir));
        check({tag, "_tok"}, 136'(token_bucket_para), 136'(m_tok));
        check({tag, "_cnt"}, 136'(update_cnt), 136'(m_cnt));
    endtask

    localparam logic [127:0] W6A = {48'h00aabbccddee, 1'b1, 15'b0, 32'h12345678, 32'b0};
    localparam logic [127:0] W6B = {48'h112233445566, 1'b0, 15'b0, 32'hcafef00d, 32'b0};
    localparam logic [127:0] W6C = {48'h665544332211, 1'b1, 15'b0, 32'h0badbeef, 32'b0};

    initial begin
        in_if.data_wr       = 1'b0;
        in_if.data          = '0;
        in_if.data_valid    = 1'b0;
        in_if.data_valid_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", {out_if.data_valid_wr, out_if.data_valid, out_if.data_wr, out_if.data[132:0]}, '0);
        check_regs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Plain IPv4 packet to the local MAC: forwarded intact.
        build(5, LOCAL, 16'h0800, '0, 1'b0);
        send(1'b1);
        idle(6);
        check_regs("plain");

        // 13-word update; registers must move exactly one edge after the tail.
        build(13, LOCAL, 16'h88f7, W6A, 1'b0);
        send(1'b1);
        check("pre_cnt", 136'(update_cnt), 136'(0));
        check("pre_mac", 136'(direct_mac_addr), 136'(0));
        idle(1);
        check("post_mac", 136'(direct_mac_addr), 136'(48'h00aabbccddee));
        check("post_dir", 136'(direction), 136'(1));
        check("post_tok", 136'(token_bucket_para), 136'(32'h12345678));
        check("post_cnt", 136'(update_cnt), 136'(1));
        idle(5);

        // Update addressed to another node: forwarded, no load.
        build(9, 48'h0a0b0c0d0eff, 16'h88f7, W6B, 1'b0);
        send(1'b1);
        idle(6);
        check_regs("othermac");

        // Invalid tail, then a 5-word update, gapless: neither commits.
        build(13, LOCAL, 16'h88f7, W6B, 1'b0);
        send(1'b0);
        build(5, LOCAL, 16'h88f7, W6B, 1'b0);
        send(1'b1);
        idle(6);
        check_regs("nocommit");

        // Forwarded / update / forwarded, back-to-back.
        build(5, LOCAL, 16'h0800, '0, 1'b0);
        send(1'b1);
        build(9, LOCAL, 16'h88f7, W6B, 1'b0);
        send(1'b1);
        build(4, CNC, 16'h0800, '0, 1'b0);
        send(1'b1);
        idle(6);
        check_regs("b2b");

        // Shortest committing update: tail is word 6.
        build(7, LOCAL, 16'h88f7, W6C, 1'b0);
        send(1'b1);
        idle(6);
        check_regs("len7");

        // Two-word packet never matches.
        build(2, LOCAL, 16'h88f7, '0, 1'b0);
        send(1'b1);
        idle(4);

        // Update aborted by a new head after word 6 was captured.
        build(8, LOCAL, 16'h88f7, W6A, 1'b1);
        send(1'b1);
        build(4, LOCAL, 16'h0800, '0, 1'b0);
        send(1'b1);
        idle(6);
        check_regs("abort");

        // Reset asserted during word 8 of an update.
        build(8, LOCAL, 16'h88f7, W6A, 1'b1);
        send(1'b1);
        @(posedge clk);
        #1;
        in_if.data = {2'b11, 4'h0, 128'h5};
        rst_n = 1'b0;
        sb.delete();
        m_mac = '0; m_dir = 1'b0; m_tok = '0; m_cnt = '0;
        @(negedge clk);
        check("mid_rst_out", {out_if.data_valid_wr, out_if.data_valid, out_if.data_wr, out_if.data[132:0]}, '0);
        check_regs("mid_rst");
        idle(1);
        #1 rst_n = 1'b1;
        idle(1);
        build(5, LOCAL, 16'h0800, '0, 1'b0);
        send(1'b1);
        idle(6);
        check_regs("after_rst");

        idle(4);
        check("sb_empty", 136'(sb.size()), 136'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lupdate.md
# lupdate

Consumes the 134-bit packet stream leaving the beacon-report stage (lreport) and recognises beacon update messages from the CNC addressed to this node. From each valid update it loads the beacon configuration registers (direct MAC, direction, token-bucket parameter) that lreport reports back. All other packets pass through over a fixed-latency delay line. Update messages are removed from the stream unless forwarding is compiled in.

## Interface
- `CNC_MAC`, default 48'h010203040506: source MAC that an update must carry.
- `UPD_TYPE`, default 4'hf: message type nibble that identifies an update.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_lu_data_wr`  in  1  input word strobe.
- `in_lu_data`  in  134  input word. [133:132]: 01 head, 11 middle, 10 tail. [131:128] reserved. [127:0] payload.
- `in_lu_data_valid`  in  1  packet-valid flag; meaningful on the tail only.
- `in_lu_data_valid_wr`  in  1  strobe for `in_lu_data_valid`.
- `in_local_mac_id`  in  48  this node's MAC.
- `out_lu_data_wr`, `out_lu_data`, `out_lu_data_valid`, `out_lu_data_valid_wr`  out  1/134/1/1  delayed stream.
- `direction`  out  1  beacon direction register.
- `token_bucket_para`  out  32  token-bucket register.
- `direct_mac_addr`  out  48  direct-neighbour MAC register.
- `update_cnt`  out  32  count of committed updates.

## Operation
- Word index counter, 4 bits:
  - Cleared to 0 by a head word (wr=1, [133:132]=01).
  - Increments on every later written word.
  - Saturates at 15.
- Match test on word 2. All four conditions must hold:
  - payload[127:80] == `in_local_mac_id`
  - payload[79:32] == `CNC_MAC`
  - payload[31:16] == 16'h88f7
  - payload[11:8] == `UPD_TYPE`
- If the match test passes, the packet is marked as an update.
- Word 6 of an update is captured into shadow registers:
  - direct MAC = payload[127:80]
  - direction = payload[79]
  - token = payload[63:32]
- Commit: on the tail of an update with `in_lu_data_valid`=1, and only if word 6 was captured:
  - shadows copy into the output registers;
  - `update_cnt` increments and wraps at 2^32.
- No commit in these cases; output registers keep their old values:
  - tail of an update with valid=0;
  - update shorter than 7 words.
- A head arriving before the previous tail aborts the open packet. Its shadows are discarded and there is no commit.
- Packets of fewer than 3 words are never updates and are forwarded.
- Delay line: 3 register stages.
  - Each stage carries the data, wr, valid, valid_wr and a drop tag.
  - The drop tag is set on every word of an update packet before that word leaves stage 3.
  - Words with the drop tag set produce `out_lu_data_wr`=0 and zero data.
- Register bits not written by this block are ignored.

## Timing
- Reset values: all outputs 0, including the configuration registers and `update_cnt`. Reset clears the delay line, word counter, shadows and drop tags.
- A reset in the middle of a packet discards that packet. The next word is treated as the start of a new packet.
- Forward latency: an input word at cycle t appears at the output at cycle t+3.
- Idle cycles (wr=0) are preserved one-for-one.
- Back-to-back packets with zero gap are supported. The drop decision for one packet never affects its neighbours.
- Configuration registers change 1 cycle after the committing tail is accepted, i.e. at t+1. This is earlier than the tail would appear at the output.
- No backpressure. The input is assumed to be accepted every cycle.

## Configuration
- `LUPDATE_FWD_UPDATE_EN`
  - Defined: update packets are forwarded unmodified (drop tag forced to 0). Register loading and counting are unchanged.
  - Undefined: update packets are removed from the stream completely.

## Test plan
- Non-update packet of 5 words (word 2 ethertype 0x0800), gapless: output is identical at +3 cycles; registers stay 0.
- Update of 13 words to the local MAC with word 6 = {48'h00aabbccddee, 1, 15'b0, 32'h12345678, 32'b0} and valid=1:
  - registers become 00aabbccddee / 1 / 12345678;
  - `update_cnt`=1;
  - no output words, or all 13 words at +3 when `LUPDATE_FWD_UPDATE_EN` is defined.
- Update with dst MAC ≠ local: forwarded; registers unchanged.
- Update whose tail has valid=0, followed by an update of 5 words: no commit in either case; both are dropped.
- Forwarded packet, then an update, then a forwarded packet, all back-to-back: outer packets arrive intact and in order; the update is absent.
- `rst_n` asserted during word 8 of an update: outputs are 0; the next packet is forwarded normally; `update_cnt`=0.
